// File: rtl/count_chk.sv
// count_chk: cycle-accurate checker for a 4-bit loadable up/down counter; results registered, visible one cycle after the compare edge.
// No backpressure; COUNT_CHK_CAPTURE_EN adds first-mismatch capture registers (first_exp/first_obs/first_cyc).
module count_chk #(
   parameter int WIDTH        = 4,
   parameter int ERR_W        = 8,
   parameter int CHK_W        = 16,
   parameter int STOP_ON_FAIL = 0,
   parameter int RESYNC       = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic [WIDTH-1:0] din,
   input  logic             load,
   input  logic             up_down,
   input  logic [WIDTH-1:0] count,
   output logic             mismatch,
   output logic             err_sticky,
   output logic [ERR_W-1:0] err_count,
   output logic [CHK_W-1:0] chk_count,
   output logic [WIDTH-1:0] exp_count,
   output logic [1:0]       state,
   output logic [WIDTH-1:0] first_exp,
   output logic [WIDTH-1:0] first_obs,
   output logic [CHK_W-1:0] first_cyc
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SYNC  = 2'd1,
      CHECK = 2'd2,
      FAIL  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   exp_q, exp_d;
   logic [ERR_W-1:0]   err_q, err_d;
   logic [CHK_W-1:0]   chk_q, chk_d;
   logic               sticky_q, sticky_d;
   logic               mm_q, mm_d;

   function automatic logic [WIDTH-1:0] nxt(input logic [WIDTH-1:0] base);
      if (load)
         return din;
      else if (up_down)
         return base + WIDTH'(1);
      else
         return base - WIDTH'(1);
   endfunction

   always_comb begin
      state_d  = state_q;
      exp_d    = exp_q;
      err_d    = err_q;
      chk_d    = chk_q;
      sticky_d = sticky_q;
      mm_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (enable)
               state_d = SYNC;
         end
         SYNC: begin
            if (!enable) begin
               state_d = IDLE;
            end else begin
               exp_d   = nxt(count);
               state_d = CHECK;
            end
         end
         CHECK: begin
            // Dropping enable wins over a pending mismatch: no compare this edge.
            if (!enable) begin
               state_d = IDLE;
            end else begin
               chk_d = (chk_q == '1) ? chk_q : chk_q + CHK_W'(1);
               if (count != exp_q) begin
                  mm_d     = 1'b1;
                  err_d    = (err_q == '1) ? err_q : err_q + ERR_W'(1);
                  sticky_d = 1'b1;
                  exp_d    = (RESYNC != 0) ? nxt(count) : nxt(exp_q);
                  if (STOP_ON_FAIL != 0)
                     state_d = FAIL;
               end else begin
                  exp_d = nxt(exp_q);
               end
            end
         end
         FAIL: begin
            state_d = FAIL;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         exp_q    <= '0;
         err_q    <= '0;
         chk_q    <= '0;
         sticky_q <= 1'b0;
         mm_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         exp_q    <= exp_d;
         err_q    <= err_d;
         chk_q    <= chk_d;
         sticky_q <= sticky_d;
         mm_q     <= mm_d;
      end
   end

   assign mismatch   = mm_q;
   assign err_sticky = sticky_q;
   assign err_count  = err_q;
   assign chk_count  = chk_q;
   assign exp_count  = exp_q;
   assign state      = state_q;

`ifdef COUNT_CHK_CAPTURE_EN
   logic [WIDTH-1:0] fexp_q, fobs_q;
   logic [CHK_W-1:0] fcyc_q;
   logic             first_hit;

   // sticky_q is still clear only on the very first failing compare.
   assign first_hit = mm_d && !sticky_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fexp_q <= '0;
         fobs_q <= '0;
         fcyc_q <= '0;
      end else if (first_hit) begin
         fexp_q <= exp_q;
         fobs_q <= count;
         fcyc_q <= chk_d;
      end
   end

   assign first_exp = fexp_q;
   assign first_obs = fobs_q;
   assign first_cyc = fcyc_q;
`else
   assign first_exp = '0;
   assign first_obs = '0;
   assign first_cyc = '0;
`endif

endmodule

// File: tb/tb_count_chk.sv
// Directed bench for count_chk: default, RESYNC=0 and STOP_ON_FAIL=1 instances share one stimulus.
module tb_count_chk;

   logic       clock;
   logic       reset;
   logic       enable;
   logic [3:0] din;
   logic       load;
   logic       up_down;
   logic [3:0] count;

   logic        a_mm, a_stk;  logic [7:0] a_err; logic [15:0] a_chk; logic [3:0] a_exp; logic [1:0] a_st;
   logic [3:0]  a_fexp, a_fobs; logic [15:0] a_fcyc;
   logic        b_mm, b_stk;  logic [7:0] b_err; logic [15:0] b_chk; logic [3:0] b_exp; logic [1:0] b_st;
   logic [3:0]  b_fexp, b_fobs; logic [15:0] b_fcyc;
   logic        c_mm, c_stk;  logic [7:0] c_err; logic [15:0] c_chk; logic [3:0] c_exp; logic [1:0] c_st;
   logic [3:0]  c_fexp, c_fobs; logic [15:0] c_fcyc;

   count_chk dut (
      .clock(clock), .reset(reset), .enable(enable), .din(din), .load(load), .up_down(up_down),
      .count(count), .mismatch(a_mm), .err_sticky(a_stk), .err_count(a_err), .chk_count(a_chk),
      .exp_count(a_exp), .state(a_st), .first_exp(a_fexp), .first_obs(a_fobs), .first_cyc(a_fcyc)
   );

   count_chk #(.RESYNC(0)) dut_nr (
      .clock(clock), .reset(reset), .enable(enable), .din(din), .load(load), .up_down(up_down),
      .count(count), .mismatch(b_mm), .err_sticky(b_stk), .err_count(b_err), .chk_count(b_chk),
      .exp_count(b_exp), .state(b_st), .first_exp(b_fexp), .first_obs(b_fobs), .first_cyc(b_fcyc)
   );

   count_chk #(.STOP_ON_FAIL(1)) dut_sf (
      .clock(clock), .reset(reset), .enable(enable), .din(din), .load(load), .up_down(up_down),
      .count(count), .mismatch(c_mm), .err_sticky(c_stk), .err_count(c_err), .chk_count(c_chk),
      .exp_count(c_exp), .state(c_st), .first_exp(c_fexp), .first_obs(c_fobs), .first_cyc(c_fcyc)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic       en, ld, ud;
      logic [3:0] din, cnt;
      logic       mm;
      int         err, chk, expv, st;
      logic       stk;
   } vec_t;

   vec_t vecs[19];
   int   tests  = 0;
   int   failed = 0;

`ifdef COUNT_CHK_CAPTURE_EN
   localparam int FEXP = 8, FOBS = 9, FCYC = 3;
`else
   localparam int FEXP = 0, FOBS = 0, FCYC = 0;
`endif

   function automatic vec_t mk(input logic en, ld, ud, input int d, c, input logic mm,
                               input int err, chk, expv, st, input logic stk);
      vec_t v;
      v.en = en; v.ld = ld; v.ud = ud; v.din = 4'(d); v.cnt = 4'(c);
      v.mm = mm; v.err = err; v.chk = chk; v.expv = expv; v.st = st; v.stk = stk;
      return v;
   endfunction

   task automatic check(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         failed++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic en, ld, ud, input logic [3:0] d, c);
      enable = en; load = ld; up_down = ud; din = d; count = c;
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
      @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      logic [3:0] my_exp;
      logic       all_mm;
      string      nm;

      //        en ld ud din cnt   mm err chk exp st stk
      vecs[0]  = mk(1, 1, 1,  5,  0,  0, 0,  0,  0, 1, 0);
      vecs[1]  = mk(1, 0, 1,  0,  5,  0, 0,  0,  6, 2, 0);
      vecs[2]  = mk(1, 0, 1,  0,  6,  0, 0,  1,  7, 2, 0);
      vecs[3]  = mk(1, 0, 1,  0,  7,  0, 0,  2,  8, 2, 0);
      vecs[4]  = mk(1, 0, 1,  0,  9,  1, 1,  3, 10, 2, 1);
      vecs[5]  = mk(1, 0, 1,  0, 10,  0, 1,  4, 11, 2, 1);
      vecs[6]  = mk(1, 1, 1, 14, 11,  0, 1,  5, 14, 2, 1);
      vecs[7]  = mk(1, 0, 1,  0, 14,  0, 1,  6, 15, 2, 1);
      vecs[8]  = mk(1, 0, 1,  0, 15,  0, 1,  7,  0, 2, 1);
      vecs[9]  = mk(1, 1, 0,  1,  0,  0, 1,  8,  1, 2, 1);
      vecs[10] = mk(1, 0, 0,  0,  1,  0, 1,  9,  0, 2, 1);
      vecs[11] = mk(1, 0, 0,  0,  0,  0, 1, 10, 15, 2, 1);
      vecs[12] = mk(1, 1, 1, 12, 15,  0, 1, 11, 12, 2, 1);
      vecs[13] = mk(0, 0, 1,  0,  3,  0, 1, 11, 12, 0, 1);
      vecs[14] = mk(1, 0, 1,  0,  4,  0, 1, 11, 12, 1, 1);
      vecs[15] = mk(1, 0, 1,  0,  4,  0, 1, 11,  5, 2, 1);
      vecs[16] = mk(1, 0, 1,  0,  5,  0, 1, 12,  6, 2, 1);
      vecs[17] = mk(1, 0, 1,  0,  9,  1, 2, 13, 10, 2, 1);
      vecs[18] = mk(1, 0, 1,  0, 10,  0, 2, 14, 11, 2, 1);

      reset = 1'b1;
      drive(1'b1, 1'b1, 1'b1, 4'd7, 4'd3);
      step();
      step();
      check("rst_mismatch", int'(a_mm), 0);
      check("rst_sticky", int'(a_stk), 0);
      check("rst_err", int'(a_err), 0);
      check("rst_chk", int'(a_chk), 0);
      check("rst_exp", int'(a_exp), 0);
      check("rst_state", int'(a_st), 0);
      check("rst_first_cyc", int'(a_fcyc), 0);

      do_reset();
      for (int i = 0; i < 19; i++) begin
         drive(vecs[i].en, vecs[i].ld, vecs[i].ud, vecs[i].din, vecs[i].cnt);
         step();
         nm = $sformatf("vec%0d", i);
         check({nm, "_mismatch"}, int'(a_mm), int'(vecs[i].mm));
         check({nm, "_err"}, int'(a_err), vecs[i].err);
         check({nm, "_chk"}, int'(a_chk), vecs[i].chk);
         check({nm, "_exp"}, int'(a_exp), vecs[i].expv);
         check({nm, "_state"}, int'(a_st), vecs[i].st);
         check({nm, "_sticky"}, int'(a_stk), int'(vecs[i].stk));
      end
      check("first_exp", int'(a_fexp), FEXP);
      check("first_obs", int'(a_fobs), FOBS);
      check("first_cyc", int'(a_fcyc), FCYC);

      // RESYNC=0: model keeps stepping from its own stale value, DUT runs offset by 8.
      do_reset();
      drive(1'b1, 1'b0, 1'b1, 4'd0, 4'd0);
      step();
      step();
      check("nr_state", int'(b_st), 2);
      check("nr_exp_seed", int'(b_exp), 1);
      my_exp = 4'd1;
      all_mm = 1'b1;
      for (int i = 1; i <= 260; i++) begin
         count = my_exp ^ 4'h8;
         step();
         my_exp = my_exp + 4'd1;
         if (b_mm !== 1'b1) all_mm = 1'b0;
         if (i == 1)   check("nr_err_first", int'(b_err), 1);
         if (i == 254) check("nr_err_254", int'(b_err), 254);
         if (i == 255) check("nr_err_255", int'(b_err), 255);
      end
      check("nr_mismatch_every_cycle", int'(all_mm), 1);
      check("nr_err_saturated", int'(b_err), 255);
      check("nr_chk", int'(b_chk), 260);
      check("nr_sticky", int'(b_stk), 1);
      check("nr_exp_track", int'(b_exp), int'(my_exp));

      // STOP_ON_FAIL=1: one pulse, then frozen in FAIL until reset.
      do_reset();
      drive(1'b1, 1'b0, 1'b1, 4'd0, 4'd0);
      step();
      check("sf_sync_state", int'(c_st), 1);
      step();
      check("sf_check_state", int'(c_st), 2);
      count = 4'd1;
      step();
      check("sf_pass_chk", int'(c_chk), 1);
      check("sf_pass_mm", int'(c_mm), 0);
      count = 4'd5;
      step();
      check("sf_fail_state", int'(c_st), 3);
      check("sf_fail_mm", int'(c_mm), 1);
      check("sf_fail_chk", int'(c_chk), 2);
      check("sf_fail_err", int'(c_err), 1);
      check("sf_fail_exp", int'(c_exp), 6);
      count = 4'd3;
      step();
      count = 4'd7;
      step();
      check("sf_frozen_state", int'(c_st), 3);
      check("sf_frozen_mm", int'(c_mm), 0);
      check("sf_frozen_chk", int'(c_chk), 2);
      check("sf_frozen_err", int'(c_err), 1);
      check("sf_frozen_exp", int'(c_exp), 6);
      #2 reset = 1'b1;
      #1;
      check("sf_rst_state", int'(c_st), 0);
      check("sf_rst_sticky", int'(c_stk), 0);
      check("sf_rst_err", int'(c_err), 0);
      check("sf_rst_chk", int'(c_chk), 0);
      check("sf_rst_exp", int'(c_exp), 0);
      check("sf_rst_mm", int'(c_mm), 0);
      check("a_rst_err", int'(a_err), 0);
      check("a_rst_first_obs", int'(a_fobs), 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
